// File: rtl/digit_overlay_renderer.sv
// digit_overlay_renderer: draws NUM_DIGITS seven-segment digits from pixel coordinates, double-buffered at frame sync.
module digit_overlay_renderer #(
  parameter int NUM_DIGITS = 4,
  parameter int ORG_X = 100,
  parameter int ORG_Y = 100,
  parameter int DIGIT_W = 40,
  parameter int DIGIT_H = 80,
  parameter int GAP = 8,
  parameter int SEG_T = 8,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic clk,
  input  logic Rst,
  input  logic [11:0] Set_X,
  input  logic [11:0] Set_Y,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic digits_valid,
  input  logic lzb_en,
  input  logic frame_sync,
  output logic [23:0] RGB_In
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int H2 = DIGIT_H / 2;
  localparam logic [6:0] SEG_MAP [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };
  function automatic int cell_x0(input int k);
    return ORG_X + (NUM_DIGITS - 1 - k) * (DIGIT_W + GAP);
  endfunction
  logic [NUM_DIGITS-1:0][3:0] shadow, active, commit_val;
  logic [NUM_DIGITS-1:0] blank, blank_nx;
  logic zero_above, hit, s1_in, lit;
  logic [IW-1:0] idx, s1_idx;
  logic [11:0] lx, ly, s1_lx, s1_ly;
  logic [6:0] seg;
  logic top, left, right;
  assign commit_val = digits_valid ? digits_in : shadow;
  // Walk from the leftmost digit down so each cell knows whether everything above it is zero.
  always_comb begin
    zero_above = 1'b1;
    blank_nx = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      blank_nx[k] = commit_val[k] > 4'd9 || (lzb_en && k != 0 && zero_above && commit_val[k] == 4'd0);
      zero_above = zero_above && commit_val[k] == 4'd0;
    end
  end
  always_comb begin
    hit = 1'b0;
    idx = '0;
    lx = '0;
    ly = Set_Y - 12'(ORG_Y);
    for (int k = 0; k < NUM_DIGITS; k++)
      if (Set_X >= 12'(cell_x0(k)) && Set_X < 12'(cell_x0(k) + DIGIT_W)) begin
        hit = 1'b1;
        idx = IW'(k);
        lx = Set_X - 12'(cell_x0(k));
      end
    hit = hit && Set_Y >= 12'(ORG_Y) && Set_Y < 12'(ORG_Y + DIGIT_H);
  end
  assign top = s1_ly < 12'(H2);
  assign left = s1_lx < 12'(SEG_T);
  assign right = s1_lx >= 12'(DIGIT_W - SEG_T);
  assign seg = {s1_ly < 12'(SEG_T), right & top, right & ~top, s1_ly >= 12'(DIGIT_H - SEG_T),
                left & ~top, left & top,
                s1_ly >= 12'(H2 - SEG_T / 2) && s1_ly < 12'(H2 - SEG_T / 2 + SEG_T)};
  assign lit = s1_in && !blank[s1_idx] && |(seg & SEG_MAP[active[s1_idx]]);
  always_ff @(posedge clk or negedge Rst)
    if (!Rst) begin
      shadow <= '1;
      active <= '1;
      blank <= '1;
      s1_in <= 1'b0;
      s1_idx <= '0;
      s1_lx <= '0;
      s1_ly <= '0;
      RGB_In <= '0;
    end else begin
      if (digits_valid) shadow <= digits_in;
      if (frame_sync) begin
        active <= commit_val;
        blank <= blank_nx;
      end
      s1_in <= hit;
      s1_idx <= idx;
      s1_lx <= lx;
      s1_ly <= ly;
      RGB_In <= lit ? FG_COLOR : BG_COLOR;
    end
endmodule

// File: tb/tb_digit_overlay_renderer.sv
// tb_digit_overlay_renderer: directed pixel probes with a queued scoreboard checked by a separate monitor.
module tb_digit_overlay_renderer;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  typedef struct {
    int due;
    logic [23:0] exp;
    string name;
  } item_t;
  logic clk, Rst, digits_valid, lzb_en, frame_sync;
  logic [11:0] Set_X, Set_Y;
  logic [15:0] digits_in;
  logic [23:0] RGB_In;
  item_t q[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  digit_overlay_renderer dut (
    .clk(clk), .Rst(Rst), .Set_X(Set_X), .Set_Y(Set_Y), .digits_in(digits_in),
    .digits_valid(digits_valid), .lzb_en(lzb_en), .frame_sync(frame_sync), .RGB_In(RGB_In)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (q.size() != 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      vectors++;
      if (RGB_In !== it.exp || it.due != cyc) begin
        miscompares++;
        $display("FAIL %s: RGB_In=%h expected %h (cycle %0d, due %0d)", it.name, RGB_In, it.exp, cyc, it.due);
      end
    end
  task automatic expect_at(input int due, input logic [23:0] e, input string n);
    item_t it;
    it.due = due;
    it.exp = e;
    it.name = n;
    q.push_back(it);
  endtask
  task automatic pix(input int x, input int y, input logic [23:0] e, input string n);
    @(posedge clk);
    #1;
    Set_X = 12'(x);
    Set_Y = 12'(y);
    expect_at(cyc + 2, e, n);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input logic [15:0] v);
    @(posedge clk);
    #1;
    digits_in = v;
    digits_valid = 1'b1;
    @(posedge clk);
    #1;
    digits_valid = 1'b0;
  endtask
  task automatic commit(input logic lzb, input logic bypass, input logic [15:0] v);
    drain();
    @(posedge clk);
    #1;
    frame_sync = 1'b1;
    lzb_en = lzb;
    digits_valid = bypass;
    digits_in = v;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    digits_valid = 1'b0;
  endtask
  initial begin
    Rst = 1'b0;
    digits_valid = 1'b0;
    lzb_en = 1'b0;
    frame_sync = 1'b0;
    digits_in = '0;
    Set_X = 12'd0;
    Set_Y = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, BG, "reset_rgb");
    @(posedge clk);
    #1;
    Rst = 1'b1;
    pix(135, 110, BG, "reset_blank_digits");
    load(16'h1234);
    commit(1'b0, 1'b0, 16'h0);
    pix(120, 102, BG, "t1_one_no_a");
    pix(135, 110, FG, "t1_one_b");
    pix(143, 110, BG, "t1_gap");
    pix(50, 50, BG, "t1_outside");
    load(16'h0042);
    commit(1'b1, 1'b0, 16'h0);
    pix(120, 102, BG, "t2_lzb_cell3");
    pix(168, 102, BG, "t2_lzb_cell2");
    pix(220, 102, BG, "t2_four_no_a");
    pix(231, 110, FG, "t2_four_b");
    pix(250, 102, FG, "t2_two_a");
    commit(1'b0, 1'b0, 16'h0);
    pix(120, 102, FG, "t2_nolzb_zero_a");
    load(16'h0000);
    commit(1'b1, 1'b0, 16'h0);
    pix(250, 102, FG, "t3_zero_cell0_a");
    pix(220, 102, BG, "t3_zero_cell1_blank");
    pix(264, 140, BG, "t3_zero_centre");
    load(16'h0008);
    commit(1'b1, 1'b0, 16'h0);
    pix(264, 140, FG, "t3_eight_g");
    load(16'h5678);
    pix(264, 140, FG, "t4_hold_cell0");
    pix(120, 140, BG, "t4_hold_cell3");
    commit(1'b1, 1'b0, 16'h0);
    pix(120, 140, FG, "t4_five_g");
    pix(150, 150, FG, "t4_six_e");
    commit(1'b1, 1'b1, 16'h9999);
    pix(150, 150, BG, "t4_bypass_nine_e");
    pix(120, 140, FG, "t4_bypass_nine_g");
    load(16'h1AF3);
    commit(1'b1, 1'b0, 16'h0);
    pix(168, 102, BG, "t5_A_blank");
    pix(220, 102, BG, "t5_F_blank");
    pix(135, 110, FG, "t5_one_b");
    pix(250, 102, FG, "t5_three_a");
    pix(264, 179, FG, "t5_three_d_lastrow");
    pix(264, 180, BG, "t5_below_cell");
    pix(283, 110, FG, "t5_lastcol_b");
    pix(284, 110, BG, "t5_right_of_cell");
    pix(135, 110, FG, "t6_before_reset");
    drain();
    @(posedge clk);
    #1;
    Rst = 1'b0;
    expect_at(cyc, BG, "t6_async_reset");
    @(posedge clk);
    #1;
    Rst = 1'b1;
    pix(135, 110, BG, "t6_blank_after_release");
    load(16'h1234);
    pix(135, 110, BG, "t6_blank_before_commit");
    commit(1'b0, 1'b0, 16'h0);
    pix(135, 110, FG, "t6_after_commit");
    drain();
    if (q.size() != 0) begin
      miscompares += q.size();
      $display("FAIL scoreboard_timeout: %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
